// File: rtl/axis_face_out_buffer.sv
// axis_face_out_buffer
//   Output stage behind the face-recognition overlay pipeline. The upstream stream has
//   valid but no ready. This block buffers it in a first-word-fall-through FIFO and
//   presents an AXI4-Stream master with tready back-pressure. Data only enters at a
//   start of frame (tuser). If a frame overflows the FIFO, the rest of that frame is
//   dropped until the next tuser beat.
//
//   Optional feature macro: FACE_OUT_LINE_CHECK_EN. When it is defined, the beat count
//   of each written line is checked and o_line_err pulses on a violation. When it is
//   undefined, o_line_err is tied 0.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_tdata/tuser/tlast     upstream beat (i_tvalid qualifies it; upstream cannot stall)
//   o_tdata/tuser/tlast     downstream beat, o_tvalid / i_tready handshake
//   o_frame_drop            one-cycle pulse when a frame starts being dropped
//   o_line_err              one-cycle pulse on a line-length violation
//   o_overflow_cnt          saturating count of rejected beats
//   o_fifo_level            current FIFO occupancy
module axis_face_out_buffer #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned H_PIX        = 1920,
  parameter int unsigned PARALLEL_NUM = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_WIDTH-1:0]         i_tdata,
  input  logic                          i_tuser,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic [DATA_WIDTH-1:0]         o_tdata,
  output logic                          o_tuser,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          i_tready,
  output logic                          o_frame_drop,
  output logic                          o_line_err,
  output logic [CNT_WIDTH-1:0]          o_overflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;
  localparam int unsigned EntryW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {StWaitSof, StPass, StDrop} state_e;

  state_e                state_q, state_d;
  logic [EntryW-1:0]     mem [FIFO_DEPTH];
  logic [EntryW-1:0]     rd_entry;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q;
  logic                  drop_q, drop_d;
  logic                  empty, pop, can_write, wr_en, ovf_inc;

  assign empty     = (level_q == '0);
  assign pop       = !empty && i_tready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a beat.
  assign can_write = (level_q != LvlW'(FIFO_DEPTH)) || pop;

  // Admission FSM: only tuser beats may open a frame. A rejected beat in PASS
  // drops the rest of that frame.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    ovf_inc = 1'b0;
    drop_d  = 1'b0;
    if (i_tvalid) begin
      unique case (state_q)
        StWaitSof, StDrop: begin
          if (i_tuser) begin
            if (can_write) begin
              wr_en   = 1'b1;
              state_d = StPass;
            end else begin
              ovf_inc = 1'b1;
            end
          end
        end
        StPass: begin
          if (can_write) begin
            wr_en = 1'b1;
          end else begin
            ovf_inc = 1'b1;
            drop_d  = 1'b1;
            state_d = StDrop;
          end
        end
        default: state_d = StWaitSof;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StWaitSof;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (ovf_inc && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  // Storage needs no reset; the output is gated by the occupancy.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= {i_tuser, i_tlast, i_tdata};
  end

  assign rd_entry       = mem[rd_ptr_q];
  assign o_tvalid       = !empty;
  assign o_tdata        = empty ? '0 : rd_entry[DATA_WIDTH-1:0];
  assign o_tlast        = !empty && rd_entry[DATA_WIDTH];
  assign o_tuser        = !empty && rd_entry[DATA_WIDTH+1];
  assign o_fifo_level   = level_q;
  assign o_overflow_cnt = ovf_cnt_q;
  assign o_frame_drop   = drop_q;

`ifdef FACE_OUT_LINE_CHECK_EN
  localparam int unsigned Expected = H_PIX / PARALLEL_NUM;
  localparam int unsigned LcW      = $clog2(Expected) + 1;

  logic [LcW-1:0] beat_cnt_q, beat_cnt_d, beat_idx;
  logic           seen_q, seen_d, seen;
  logic           line_err_q, line_err_d;

  // A tuser beat is index 0 of a fresh line. seen_q stops a second report on a line
  // that has already been flagged.
  always_comb begin
    beat_idx   = i_tuser ? '0 : beat_cnt_q;
    seen       = i_tuser ? 1'b0 : seen_q;
    beat_cnt_d = beat_cnt_q;
    seen_d     = seen_q;
    line_err_d = 1'b0;
    if (wr_en) begin
      if (i_tlast) line_err_d = !seen && (beat_idx != LcW'(Expected - 1));
      else         line_err_d = !seen && (beat_idx == LcW'(Expected - 1));
      beat_cnt_d = i_tlast ? '0 : ((beat_idx == '1) ? beat_idx : beat_idx + 1'b1);
      seen_d     = i_tlast ? 1'b0 : (seen || line_err_d);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt_q <= '0;
      seen_q     <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      seen_q     <= seen_d;
      line_err_q <= line_err_d;
    end
  end

  assign o_line_err = line_err_q;
`else
  assign o_line_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_face_out_buffer.sv
module tb_axis_face_out_buffer;
  localparam int DW = 128, DEPTH = 8, HPIX = 16, PN = 4, CW = 4, LW = 4;
  localparam int E = HPIX / PN;
  localparam int OVF_MAX = (1 << CW) - 1;
`ifdef FACE_OUT_LINE_CHECK_EN
  localparam bit LCHK = 1'b1;
`else
  localparam bit LCHK = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_tdata;
  logic          i_tuser, i_tlast, i_tvalid, i_tready;
  logic [DW-1:0] o_tdata;
  logic          o_tuser, o_tlast, o_tvalid, o_frame_drop, o_line_err;
  logic [CW-1:0] o_overflow_cnt;
  logic [LW-1:0] o_fifo_level;

  always #5 i_clk = ~i_clk;

  axis_face_out_buffer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .H_PIX(HPIX), .PARALLEL_NUM(PN), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_frame_drop(o_frame_drop),
    .o_line_err(o_line_err), .o_overflow_cnt(o_overflow_cnt), .o_fifo_level(o_fifo_level)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a queue of {tuser,tlast,data} plus the frame-admission mode
  // (0 = waiting for SOF, 1 = passing, 2 = dropping).
  typedef logic [DW+1:0] entry_t;
  entry_t mq[$];
  int m_mode, m_ovf, m_lidx;
  bit m_drop, m_lerr, m_lseen;

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_ovf = 0; m_lidx = 0; m_drop = 0; m_lerr = 0; m_lseen = 0;
  endtask

  task automatic compare_all();
    check("valid", o_tvalid, mq.size() > 0);
    if (mq.size() > 0) check("head", {o_tuser, o_tlast, o_tdata}, mq[0]);
    check("level", o_fifo_level, mq.size());
    check("ovf_cnt", o_overflow_cnt, m_ovf);
    check("frame_drop", o_frame_drop, m_drop);
    check("line_err", o_line_err, m_lerr);
  endtask

  // One clock: drive at negedge, predict, step, compare at the next negedge.
  task automatic cyc(input bit v, input bit u, input bit l, input logic [DW-1:0] d,
                     input bit r);
    bit pop, cw, wr, nd, lerr;
    int idx;
    bit seen;
    i_tvalid = v; i_tuser = u; i_tlast = l; i_tdata = d; i_tready = r;
    pop = (mq.size() > 0) && r;
    cw  = (mq.size() < DEPTH) || pop;
    wr = 0; nd = 0; lerr = 0;
    if (v) begin
      if (m_mode == 1) begin
        if (cw) wr = 1;
        else begin
          nd = 1; m_mode = 2;
          if (m_ovf < OVF_MAX) m_ovf++;
        end
      end else if (u) begin
        if (cw) begin wr = 1; m_mode = 1; end
        else if (m_ovf < OVF_MAX) m_ovf++;
      end
    end
    if (LCHK && wr) begin
      idx  = u ? 0 : m_lidx;
      seen = u ? 1'b0 : m_lseen;
      lerr = !seen && (l ? (idx != E - 1) : (idx == E - 1));
      m_lidx  = l ? 0 : idx + 1;
      m_lseen = l ? 1'b0 : (seen | lerr);
    end
    @(posedge i_clk);
    if (pop) void'(mq.pop_front());
    if (wr) mq.push_back({u, l, d});
    m_drop = nd;
    m_lerr = lerr;
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_tvalid = 0; i_tuser = 0; i_tlast = 0; i_tdata = '0; i_tready = 0;
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    bit v, u, l;
    logic [DW-1:0] d;
    bit r;
    bit ev, eu;
    logic [DW-1:0] ed;
    int elvl;
  } vec_t;

  vec_t tbl[6];
  logic [DW-1:0] a5;
  int drops, pops, lerrs, ovf0;

  initial begin
    a5 = {16{8'hA5}};
    tbl[0] = '{1, 0, 0, 128'h1, 1, 0, 0, '0, 0};
    tbl[1] = '{1, 0, 0, 128'h2, 1, 0, 0, '0, 0};
    tbl[2] = '{1, 0, 0, 128'h3, 1, 0, 0, '0, 0};
    tbl[3] = '{1, 1, 0, a5,     1, 1, 1, a5, 1};
    tbl[4] = '{0, 0, 0, '0,     1, 0, 0, '0, 0};
    tbl[5] = '{0, 0, 0, '0,     1, 0, 0, '0, 0};

    // Reset state
    do_reset();
    check("rst_tvalid", o_tvalid, 1'b0);
    check("rst_tdata", o_tdata, '0);
    check("rst_tuser_tlast", {o_tuser, o_tlast}, 2'b00);
    check("rst_level", o_fifo_level, 0);
    check("rst_ovf", o_overflow_cnt, 0);
    check("rst_pulses", {o_frame_drop, o_line_err}, 2'b00);

    // 1: non-tuser beats discarded, SOF appears one cycle later
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].v, tbl[i].u, tbl[i].l, tbl[i].d, tbl[i].r);
      check("t1_valid", o_tvalid, tbl[i].ev);
      check("t1_level", o_fifo_level, tbl[i].elvl);
      if (tbl[i].ev) check("t1_user_data", {o_tuser, o_tdata}, {tbl[i].eu, tbl[i].ed});
    end

    // 2: two 4-beat lines with tready high
    for (int i = 0; i < 8; i++) begin
      cyc(1, i == 0, (i % 4) == 3, rnd_data(), 1);
      check("t2_level_le1", o_fifo_level <= 1, 1'b1);
    end
    repeat (2) cyc(0, 0, 0, '0, 1);

    // 3: overflow and frame drop
    do_reset();
    drops = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1, i == 0, 0, rnd_data(), 0);
      if (o_frame_drop) drops++;
    end
    check("t3_level_full", o_fifo_level, DEPTH);
    check("t3_drop_pulse", o_frame_drop, 1'b1);
    check("t3_ovf", o_overflow_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, i == 3, rnd_data(), 0);
      if (o_frame_drop) drops++;
    end
    check("t3_drop_count", drops, 1);
    check("t3_ovf_hold", o_overflow_cnt, 1);
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_tvalid) pops++;
      cyc(1, 0, 0, rnd_data(), 1);
    end
    check("t3_drained", pops, 8);
    for (int i = 0; i < 4; i++) cyc(1, i == 0, i == 3, rnd_data(), 1);
    repeat (2) cyc(0, 0, 0, '0, 1);

    // 4: full FIFO with simultaneous pop and write
    for (int i = 0; i < DEPTH; i++) cyc(1, i == 0, (i % 4) == 3, rnd_data(), 0);
    ovf0 = o_overflow_cnt;
    cyc(1, 0, 0, rnd_data(), 1);
    check("t4_level_stays", o_fifo_level, DEPTH);
    check("t4_ovf_same", o_overflow_cnt, ovf0);
    check("t4_no_drop", o_frame_drop, 1'b0);

    // Overflow counter saturation: tuser beats refused while full
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, rnd_data(), 0);
    check("ovf_saturate", o_overflow_cnt, OVF_MAX);
    repeat (10) cyc(0, 0, 0, '0, 1);

    // 5: line length check
    do_reset();
    lerrs = 0;
    for (int i = 0; i < 3; i++) cyc(1, i == 0, i == 2, rnd_data(), 1);
    check("t5_short_line", o_line_err, LCHK);
    cyc(0, 0, 0, '0, 1);
    check("t5_pulse_1cyc", o_line_err, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, i == 4, rnd_data(), 1);
      if (i == 3) check("t5_long_line", o_line_err, LCHK);
      if (o_line_err) lerrs++;
    end
    cyc(0, 0, 0, '0, 1);
    if (o_line_err) lerrs++;
    check("t5_single_pulse", lerrs, LCHK ? 1 : 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, i == 3, rnd_data(), 1);
    cyc(0, 0, 0, '0, 1);

    // 6: reset mid-frame
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, i == 0, 0, rnd_data(), 0);
    check("t6_level5", o_fifo_level, 5);
    #2 i_rst = 1'b1;
    #1;
    check("t6_rst_valid", o_tvalid, 1'b0);
    check("t6_rst_level", o_fifo_level, 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, rnd_data(), 1);
    check("t6_discard", o_tvalid, 1'b0);
    cyc(1, 1, 0, a5, 1);
    check("t6_fresh_sof", {o_tvalid, o_tuser, o_tdata}, {2'b11, a5});
    repeat (3) cyc(0, 0, 0, '0, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
          rnd_data(), $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
